// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: register file geometry and writeback
// request types used by the register file controller.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam int ADDR = 5;
   localparam int NREG = 2 ** ADDR;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic            valid;
      logic [ADDR-1:0] rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage : riscv_pkg

// File: rtl/regfile_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter for the shared register file write port.
// rr_last remembers the most recent winner so the other side wins a tie.
module rr_arbiter2
   import riscv_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_alu,
   input  logic req_mem,
   output logic gnt_alu,
   output logic gnt_mem
);

   wb_src_e rr_last_q;
   wb_src_e rr_last_d;

   // Grant decode: a lone requester wins, a tie goes to the side not served last.
   always_comb begin
      gnt_alu = req_alu & (~req_mem | (rr_last_q == WB_MEM));
      gnt_mem = req_mem & (~req_alu | (rr_last_q == WB_ALU));
   end

   // Next winner history.
   always_comb begin
      rr_last_d = rr_last_q;
      if (gnt_alu) begin
         rr_last_d = WB_ALU;
      end else if (gnt_mem) begin
         rr_last_d = WB_MEM;
      end else begin
         rr_last_d = rr_last_q;
      end
   end

   // Winner history register; reset favours ALU on the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last_q <= WB_MEM;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end

endmodule : rr_arbiter2

// File: rtl/regfile_ctrl.sv
// Register file controller: busy scoreboard with RAW/WAW decode stall,
// round-robin sharing of the write port, and a registered write stage.
module regfile_ctrl
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            dec_valid,
   input  logic [ADDR-1:0] dec_rs1_addr,
   input  logic            dec_rs1_used,
   input  logic [ADDR-1:0] dec_rs2_addr,
   input  logic            dec_rs2_used,
   input  logic [ADDR-1:0] dec_rd_addr,
   input  logic            dec_rd_wen,
   output logic            dec_stall,
   input  logic            alu_wb_valid,
   input  logic [ADDR-1:0] alu_wb_rd,
   input  logic [XLEN-1:0] alu_wb_data,
   output logic            alu_wb_ready,
   input  logic            mem_wb_valid,
   input  logic [ADDR-1:0] mem_wb_rd,
   input  logic [XLEN-1:0] mem_wb_data,
   output logic            mem_wb_ready,
   output logic            rf_write_en,
   output logic [ADDR-1:0] rf_rd_addr,
   output logic [XLEN-1:0] rf_rd_data
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            rf_write_en_q;
   logic            rf_write_en_d;
   logic [ADDR-1:0] rf_rd_addr_q;
   logic [ADDR-1:0] rf_rd_addr_d;
   logic [XLEN-1:0] rf_rd_data_q;
   logic [XLEN-1:0] rf_rd_data_d;

   wb_req_t alu_req_s;
   wb_req_t mem_req_s;
   wb_req_t wb_sel_s;
   logic    gnt_alu_s;
   logic    gnt_mem_s;
   logic    issue_s;

   assign alu_req_s = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
   assign mem_req_s = '{valid: mem_wb_valid, rd: mem_wb_rd, data: mem_wb_data};

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_alu (alu_req_s.valid),
      .req_mem (mem_req_s.valid),
      .gnt_alu (gnt_alu_s),
      .gnt_mem (gnt_mem_s)
   );

   assign alu_wb_ready = gnt_alu_s;
   assign mem_wb_ready = gnt_mem_s;

   // Hazard check against pending writes and issue qualification.
   always_comb begin
      dec_stall = dec_valid & ((dec_rs1_used & busy_q[dec_rs1_addr]) |
                               (dec_rs2_used & busy_q[dec_rs2_addr]) |
                               (dec_rd_wen   & busy_q[dec_rd_addr]));
      issue_s   = dec_valid & ~dec_stall & dec_rd_wen & (dec_rd_addr != {ADDR{1'b0}});
   end

   // Scoreboard update: flush beats set, set beats clear; x0 never busy.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         busy_d[i] = flush                                          ? 1'b0 :
                     (issue_s && dec_rd_addr == ADDR'(i))           ? 1'b1 :
                     (rf_write_en_q && rf_rd_addr_q == ADDR'(i))    ? 1'b0 :
                                                                      busy_q[i];
      end
      busy_d[0] = 1'b0;
   end

   // Write stage: capture the granted request; addr/data hold when idle.
   always_comb begin
      wb_sel_s      = '0;
      rf_write_en_d = 1'b0;
      rf_rd_addr_d  = rf_rd_addr_q;
      rf_rd_data_d  = rf_rd_data_q;
      if (gnt_alu_s) begin
         wb_sel_s = alu_req_s;
      end else if (gnt_mem_s) begin
         wb_sel_s = mem_req_s;
      end else begin
         wb_sel_s = '0;
      end
      if (gnt_alu_s || gnt_mem_s) begin
         rf_write_en_d = (wb_sel_s.rd != {ADDR{1'b0}});
         rf_rd_addr_d  = wb_sel_s.rd;
         rf_rd_data_d  = wb_sel_s.data;
      end else begin
         rf_write_en_d = 1'b0;
      end
   end

   // State registers; reset drops any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q        <= {NREG{1'b0}};
         rf_write_en_q <= 1'b0;
         rf_rd_addr_q  <= {ADDR{1'b0}};
         rf_rd_data_q  <= {XLEN{1'b0}};
      end else begin
         busy_q        <= busy_d;
         rf_write_en_q <= rf_write_en_d;
         rf_rd_addr_q  <= rf_rd_addr_d;
         rf_rd_data_q  <= rf_rd_data_d;
      end
   end

   assign rf_write_en = rf_write_en_q;
   assign rf_rd_addr  = rf_rd_addr_q;
   assign rf_rd_data  = rf_rd_data_q;

endmodule : regfile_ctrl

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: directed vector table followed by
// randomized traffic checked against a behavioural scoreboard model.
module tb_regfile_ctrl;

   typedef struct {
      logic        rst, flush, dv;
      logic [4:0]  rs1;
      logic        r1u;
      logic [4:0]  rs2;
      logic        r2u;
      logic [4:0]  rd;
      logic        rdw;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        e_stall, e_ar, e_mr, e_wen;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, flush, dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_wen;
   logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
   logic        dec_stall;
   logic        alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
   logic [4:0]  alu_wb_rd, mem_wb_rd;
   logic [31:0] alu_wb_data, mem_wb_data;
   logic        rf_write_en;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;

   always #5 clk = ~clk;

   regfile_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dec_valid(dec_valid),
      .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
      .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
      .dec_rd_addr(dec_rd_addr), .dec_rd_wen(dec_rd_wen),
      .dec_stall(dec_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
      .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
      .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
      .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
      .rf_write_en(rf_write_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: set of pending destinations, last winner, write stage.
   bit          m_busy [32];
   int          m_rr_last;      // 0 = ALU served last, 1 = MEM served last
   bit          m_wen;
   bit [4:0]    m_addr;
   bit [31:0]   m_data;
   int          m_winner;

   vec_t tbl [26];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_rr_last = 1;
      m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
   endtask

   task automatic apply(input vec_t v, input bit use_tbl, input int idx);
      bit exp_stall;
      bit [4:0] wrd;
      bit [31:0] wdata;
      @(negedge clk);
      rst = v.rst; flush = v.flush; dec_valid = v.dv;
      dec_rs1_addr = v.rs1; dec_rs1_used = v.r1u;
      dec_rs2_addr = v.rs2; dec_rs2_used = v.r2u;
      dec_rd_addr = v.rd; dec_rd_wen = v.rdw;
      alu_wb_valid = v.av; alu_wb_rd = v.ard; alu_wb_data = v.ad;
      mem_wb_valid = v.mv; mem_wb_rd = v.mrd; mem_wb_data = v.md;
      #1;
      exp_stall = v.dv && ((v.r1u && m_busy[v.rs1]) || (v.r2u && m_busy[v.rs2]) ||
                           (v.rdw && m_busy[v.rd]));
      if (v.av && v.mv) m_winner = 1 - m_rr_last;
      else if (v.av)    m_winner = 0;
      else if (v.mv)    m_winner = 1;
      else              m_winner = -1;
      chk("model_stall", idx, {31'd0, dec_stall}, {31'd0, exp_stall});
      chk("model_alu_ready", idx, {31'd0, alu_wb_ready}, {31'd0, m_winner == 0});
      chk("model_mem_ready", idx, {31'd0, mem_wb_ready}, {31'd0, m_winner == 1});
      chk("model_wen", idx, {31'd0, rf_write_en}, {31'd0, m_wen});
      chk("model_addr", idx, {27'd0, rf_rd_addr}, {27'd0, m_addr});
      chk("model_data", idx, rf_rd_data, m_data);
      if (use_tbl) begin
         chk("tbl_stall", idx, {31'd0, dec_stall}, {31'd0, v.e_stall});
         chk("tbl_alu_ready", idx, {31'd0, alu_wb_ready}, {31'd0, v.e_ar});
         chk("tbl_mem_ready", idx, {31'd0, mem_wb_ready}, {31'd0, v.e_mr});
         chk("tbl_wen", idx, {31'd0, rf_write_en}, {31'd0, v.e_wen});
         chk("tbl_addr", idx, {27'd0, rf_rd_addr}, {27'd0, v.e_addr});
         chk("tbl_data", idx, rf_rd_data, v.e_data);
      end
      // Advance the model to the state after the coming edge.
      if (v.rst) begin
         model_reset();
      end else begin
         if (m_wen) m_busy[m_addr] = 1'b0;
         if (v.dv && !exp_stall && v.rdw && v.rd != 5'd0) m_busy[v.rd] = 1'b1;
         if (v.flush) foreach (m_busy[i]) m_busy[i] = 1'b0;
         if (m_winner >= 0) begin
            wrd   = (m_winner == 0) ? v.ard : v.mrd;
            wdata = (m_winner == 0) ? v.ad  : v.md;
            m_wen = (wrd != 5'd0); m_addr = wrd; m_data = wdata;
            m_rr_last = m_winner;
         end else begin
            m_wen = 1'b0;
         end
      end
   endtask

   initial begin
      vec_t r;
      model_reset();
      //            rst   flush dv    rs1   r1u   rs2    r2u   rd     rdw   av    ard    ad            mv    mrd    md            stl   ar    mr    wen   addr   data
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  32'h11111111, 1'b1, 5'd4,  32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h22222222, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  32'h11111111};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  32'h33333333, 1'b1, 5'd4,  32'h44444444, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  32'h22222222};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  32'h33333333};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  32'h44444444};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  32'h44444444};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  32'h44444444};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd5,  32'hA5A50005, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 5'd4,  32'h44444444};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  32'hA5A50005};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  32'hA5A50005};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  32'hA5A50005};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd5,  32'hA5A50005};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'hDEADBEEF};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'hDEADBEEF};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77777777, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'hDEADBEEF};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  32'h77777777};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'h77777777};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd9,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'h77777777};
      tbl[19] = '{1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd10, 1'b1, 1'b1, 5'd9,  32'h99999999, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd7,  32'h77777777};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  32'h99999999};
      tbl[21] = '{1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  32'h99999999};
      tbl[22] = '{1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 5'd12, 1'b1, 1'b1, 5'd12, 32'hCCCC000C, 1'b1, 5'd13, 32'hDDDD000D, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  32'h99999999};
      tbl[23] = '{1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd12, 32'hCCCC000C, 1'b1, 5'd13, 32'hEEEE000E, 1'b0, 1'b1, 1'b0, 1'b1, 5'd13, 32'hDDDD000D};
      tbl[24] = '{1'b0, 1'b0, 1'b1, 5'd12,1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd12, 32'hCCCC000C, 1'b1, 5'd13, 32'hEEEE000E, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
      tbl[25] = '{1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hCCCC000C};

      // Bring the design to a known state before the first checked cycle.
      r = tbl[0];
      rst = 1'b1; flush = 1'b0; dec_valid = 1'b0;
      dec_rs1_addr = 5'd0; dec_rs1_used = 1'b0; dec_rs2_addr = 5'd0; dec_rs2_used = 1'b0;
      dec_rd_addr = 5'd0; dec_rd_wen = 1'b0;
      alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'd0;
      mem_wb_valid = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 32'd0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 26; i++) apply(tbl[i], 1'b1, i);

      // Random traffic; writeback requesters hold their request until granted.
      r.av = 1'b0; r.mv = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         r.rst   = ($urandom_range(0, 99) == 0);
         r.flush = ($urandom_range(0, 31) == 0);
         r.dv    = $urandom_range(0, 3) != 0;
         r.rs1   = 5'($urandom_range(0, 7));
         r.r1u   = $urandom_range(0, 1) == 1;
         r.rs2   = 5'($urandom_range(0, 7));
         r.r2u   = $urandom_range(0, 1) == 1;
         r.rd    = 5'($urandom_range(0, 7));
         r.rdw   = $urandom_range(0, 1) == 1;
         if (!(r.av && m_winner != 0)) begin
            r.av  = $urandom_range(0, 1) == 1;
            r.ard = 5'($urandom_range(0, 7));
            r.ad  = $urandom;
         end
         if (!(r.mv && m_winner != 1)) begin
            r.mv  = $urandom_range(0, 1) == 1;
            r.mrd = 5'($urandom_range(0, 7));
            r.md  = $urandom;
         end
         apply(r, 1'b0, 1000 + c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_regfile_ctrl
